pad_bank_filtered: RTL and testbench

Parametrised FPGA pad bank: `NumPads` bidirectional pads, each on an `IOBUF` primitive, with runtime per-pad direction mode (input, push-pull, open-drain, disabled). Output controls are registered. Each input passes through a multi-stage synchroniser and an optional counter-based deglitch filter, then an edge detector with sticky event flags. It sits between the SoC pad-mux/GPIO logic and the FPGA I/O, and replaces the per-pad fixed-function wrappers.

---
 rtl/pad_bank_filtered.sv | 136 +++++++++++++
 tb/tb_pad_bank_filtered.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_bank_filtered.sv
// pad_bank_filtered: IOBUF-style pad bank with registered direction/output control,
// synchronised inputs, optional deglitch counters (macro PAD_BANK_FILTER_EN) and sticky edge events.
module pad_bank_filtered #(
  parameter int NumPads    = 8,
  parameter int SyncStages = 2,
  parameter int FiltWidth  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  inout  wire  [NumPads-1:0]   pad_io,
  input  logic [2*NumPads-1:0] mode_i,
  input  logic [NumPads-1:0]   out_i,
  input  logic [FiltWidth-1:0] filt_len_i,
  output logic [NumPads-1:0]   in_o,
  output logic [NumPads-1:0]   rise_o,
  output logic [NumPads-1:0]   fall_o,
  output logic [NumPads-1:0]   evt_pending_o,
  input  logic [NumPads-1:0]   evt_clr_i,
  output logic                 irq_o
);

  typedef enum logic [1:0] {
    MODE_INPUT     = 2'd0,
    MODE_PUSHPULL  = 2'd1,
    MODE_OPENDRAIN = 2'd2,
    MODE_DISABLED  = 2'd3
  } pad_mode_e;

  logic [NumPads-1:0] t_d, i_d, dis;
  logic [NumPads-1:0] t_p0, i_p0;
  logic [NumPads-1:0] sync_p [SyncStages];
  logic [NumPads-1:0] s;
  logic [NumPads-1:0] q_p1, q_p2, pend_p2;

  always_comb begin
    t_d = '1;
    i_d = '0;
    dis = '0;
    for (int k = 0; k < NumPads; k++) begin
      case (pad_mode_e'(mode_i[2*k +: 2]))
        MODE_PUSHPULL: begin
          t_d[k] = 1'b0;
          i_d[k] = out_i[k];
        end
        MODE_OPENDRAIN: t_d[k] = out_i[k];
        MODE_DISABLED:  dis[k] = 1'b1;
        default: ;
      endcase
    end
  end

  // stage p0: registered pad drive controls
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      t_p0 <= '1;
      i_p0 <= '0;
    end else begin
      t_p0 <= t_d;
      i_p0 <= i_d;
    end
  end

  // Each bit maps onto one IOBUF: T high releases the pad, O is the pad itself.
  for (genvar k = 0; k < NumPads; k++) begin : g_iobuf
    assign pad_io[k] = t_p0[k] ? 1'bz : i_p0[k];
  end

  // synchroniser stages; they keep sampling even for disabled pads
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int j = 0; j < SyncStages; j++) sync_p[j] <= '0;
    end else begin
      sync_p[0] <= pad_io;
      for (int j = 1; j < SyncStages; j++) sync_p[j] <= sync_p[j-1];
    end
  end

  assign s = sync_p[SyncStages-1];

  // stage p1: filtered input state
`ifdef PAD_BANK_FILTER_EN
  logic [FiltWidth-1:0] cnt_p1 [NumPads];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_p1 <= '0;
      for (int k = 0; k < NumPads; k++) cnt_p1[k] <= '0;
    end else begin
      for (int k = 0; k < NumPads; k++) begin
        if (dis[k] || (s[k] == q_p1[k])) begin
          cnt_p1[k] <= '0;
        end else if (cnt_p1[k] >= filt_len_i) begin
          // compare against the live length so a shortened L takes effect at once
          q_p1[k]   <= s[k];
          cnt_p1[k] <= '0;
        end else begin
          cnt_p1[k] <= cnt_p1[k] + 1'b1;
        end
      end
    end
  end
`else
  logic unused_filt_len;
  assign unused_filt_len = ^filt_len_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_p1 <= '0;
    end else begin
      for (int k = 0; k < NumPads; k++) begin
        if (!dis[k]) q_p1[k] <= s[k];
      end
    end
  end
`endif

  assign in_o = q_p1;
  // disabled pads never report edges, so entry/exit of that mode is silent
  assign rise_o = q_p1 & ~q_p2 & ~dis;
  assign fall_o = ~q_p1 & q_p2 & ~dis;

  // stage p2: edge history and sticky flags; a new edge beats a clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_p2    <= '0;
      pend_p2 <= '0;
    end else begin
      q_p2    <= q_p1;
      pend_p2 <= (pend_p2 & ~evt_clr_i) | rise_o | fall_o;
    end
  end

  assign evt_pending_o = pend_p2;
  assign irq_o         = |pend_p2;

endmodule

// File: tb/tb_pad_bank_filtered.sv
// tb_pad_bank_filtered: directed and randomized checks of pad_bank_filtered against a
// sample-history reference model; follows PAD_BANK_FILTER_EN the same way the design does.
module tb_pad_bank_filtered;
  localparam int NP = 8;
  localparam int SS = 2;
  localparam int FW = 4;
  localparam int HD = 1 << FW;

  logic clk;
  logic rst_n;
  wire  [NP-1:0] pad;
  logic [NP-1:0] drv_en, drv_val;
  logic [2*NP-1:0] mode;
  logic [NP-1:0] out, clr;
  logic [FW-1:0] flen;
  logic [NP-1:0] in_v, rise, fall, pend;
  logic irq;

  for (genvar k = 0; k < NP; k++) begin : g_pad
    assign pad[k] = drv_en[k] ? drv_val[k] : 1'bz;
    pullup (pad[k]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pad_bank_filtered #(.NumPads(NP), .SyncStages(SS), .FiltWidth(FW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .pad_io(pad), .mode_i(mode), .out_i(out),
    .filt_len_i(flen), .in_o(in_v), .rise_o(rise), .fall_o(fall),
    .evt_pending_o(pend), .evt_clr_i(clr), .irq_o(irq));

  // Reference model: pad level from drive rules, raw pad samples delayed by SS edges,
  // and a pad value accepted once the last L+1 enabled samples all disagree with it.
  logic [NP-1:0] m_t, m_i, m_q, m_qd, m_pend;
  logic [NP-1:0] ph[$];
  logic [NP-1:0] sh[$];
  logic [NP-1:0] dh[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [NP-1:0] dis_mask();
    logic [NP-1:0] d;
    d = '0;
    for (int k = 0; k < NP; k++) d[k] = (mode[2*k +: 2] == 2'd3);
    return d;
  endfunction

  function automatic logic [NP-1:0] pad_model();
    logic [NP-1:0] p;
    for (int k = 0; k < NP; k++) p[k] = drv_en[k] ? drv_val[k] : (m_t[k] ? 1'b1 : m_i[k]);
    return p;
  endfunction

  task automatic model_reset();
    m_t = '1; m_i = '0; m_q = '0; m_qd = '0; m_pend = '0;
    ph.delete(); sh.delete(); dh.delete();
    for (int j = 0; j < SS; j++) ph.push_back('0);
    for (int j = 0; j < HD; j++) begin
      sh.push_back('0);
      dh.push_back('0);
    end
  endtask

  task automatic model_edge();
    logic [NP-1:0] smp, dis, nq, pulse;
    logic [1:0] md;
    int len;
    bit ok;
`ifdef PAD_BANK_FILTER_EN
    len = int'(flen);
`else
    len = 0;
`endif
    dis = dis_mask();
    ph.push_front(pad_model());
    smp = ph[SS];
    void'(ph.pop_back());
    sh.push_front(smp); void'(sh.pop_back());
    dh.push_front(dis); void'(dh.pop_back());
    nq = m_q;
    for (int k = 0; k < NP; k++) begin
      ok = 1'b1;
      for (int j = 0; j <= len; j++) if (sh[j][k] == m_q[k] || dh[j][k]) ok = 1'b0;
      if (ok) nq[k] = smp[k];
    end
    pulse  = (m_q ^ m_qd) & ~dis;
    m_pend = (m_pend & ~clr) | pulse;
    m_qd   = m_q;
    m_q    = nq;
    for (int k = 0; k < NP; k++) begin
      md = mode[2*k +: 2];
      m_t[k] = (md == 2'd1) ? 1'b0 : ((md == 2'd2) ? out[k] : 1'b1);
      m_i[k] = (md == 2'd1) && out[k];
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("in_o", in_v, m_q);
    check("rise_o", rise, m_q & ~m_qd & ~dis_mask());
    check("fall_o", fall, ~m_q & m_qd & ~dis_mask());
    check("evt_pending_o", pend, m_pend);
    check("irq_o", irq, |m_pend);
    check("pad", pad, pad_model());
  endtask

  // Invert pad k for len cycles, then run to total cycles counting its pulses.
  task automatic glitch(input int k, input int len, input int total,
                        output int nr, output int nf, output int first_fall);
    nr = 0; nf = 0; first_fall = -1;
    drv_val[k] = ~drv_val[k];
    for (int i = 1; i <= total; i++) begin
      step();
      if (i == len) drv_val[k] = ~drv_val[k];
      nr += int'(rise[k]);
      nf += int'(fall[k]);
      if (fall[k] && first_fall < 0) first_fall = i;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nr, nf, first, cnt;
    bit found;
    logic [NP-1:0] frz;

    rst_n = 1'b0; drv_en = '0; drv_val = '0; mode = '0; out = '0; flen = '0; clr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_in", in_v, 0);
    check("rst_rise", rise, 0);
    check("rst_fall", fall, 0);
    check("rst_pend", pend, 0);
    check("rst_irq", irq, 0);
    check("rst_pad_hiz", pad, 32'hFF);

    rst_n = 1'b1;
    step(); check("rel_in_c1", in_v, 0);
    step(); check("rel_in_c2", in_v, 0);
    step(); check("rel_in_c3", in_v, 32'hFF); check("rel_rise_c3", rise, 32'hFF);
    check("rel_irq_c3", irq, 0);
    step(); check("rel_rise_c4", rise, 0); check("rel_irq_c4", irq, 1);
    clr = '1; step(); clr = '0;
    check("clr_all", pend, 0);

    // output modes on pad 0, observed through the pull-up
    mode[1:0] = 2'd1; out[0] = 1'b0;
    #1; check("pp_latency", pad[0], 1);
    step(); check("pp_out0", pad[0], 0);
    out[0] = 1'b1; step(); check("pp_out1", pad[0], 1);
    mode[1:0] = 2'd2; out[0] = 1'b0; step(); check("od_out0", pad[0], 0);
    out[0] = 1'b1; step(); check("od_out1_z", pad[0], 1);
    out[0] = 1'b0; step(); check("od_out0_b", pad[0], 0);
    mode[1:0] = 2'd0; step(); check("input_z", pad[0], 1);
    repeat (6) step();
    clr = '1; step(); clr = '0;

    // deglitch on pad 1
    drv_en[1] = 1'b1; drv_val[1] = 1'b1;
`ifdef PAD_BANK_FILTER_EN
    flen = 4'd3;
    repeat (2) step();
    glitch(1, 3, 14, nr, nf, first);
    check("glitch3_rise", nr, 0); check("glitch3_fall", nf, 0);
    check("glitch3_pend", pend[1], 0); check("glitch3_in", in_v[1], 1);
    glitch(1, 4, 14, nr, nf, first);
    check("glitch4_rise", nr, 1); check("glitch4_fall", nf, 1);
    check("glitch4_lat", first, 6);
`else
    flen = 4'd3;
    repeat (2) step();
    glitch(1, 1, 8, nr, nf, first);
    check("glitch1_rise", nr, 1); check("glitch1_fall", nf, 1);
    check("glitch1_lat", first, 3);
`endif
    clr = '1; step(); clr = '0;

    // set/clear collision on pad 2
    flen = '0;
    drv_en[2] = 1'b1; drv_val[2] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step();
      found = fall[2];
    end
    check("coll_fall_seen", found, 1);
    clr[2] = 1'b1; step(); check("coll_set_wins", pend[2], 1);
    step(); clr[2] = 1'b0;
    check("clr_alone", pend[2], 0); check("clr_irq", irq, 0);

    // disabled mode on pad 3
    drv_en[3] = 1'b1; drv_val[3] = 1'b1;
    repeat (2) step();
    mode[7:6] = 2'd3; step();
    frz = in_v; nr = 0;
    for (int i = 0; i < 10; i++) begin
      drv_val[3] = ~i[0];
      step();
      nr += int'(rise[3]) + int'(fall[3]);
    end
    repeat (2) step();
    check("dis_frozen", in_v[3], frz[3]); check("dis_pulses", nr, 0);
    mode[7:6] = 2'd0;
    found = 1'b0; cnt = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      step();
      cnt++;
      found = fall[3];
    end
    check("dis_exit_edge", found, 1); check("dis_exit_lat", cnt, 1);

`ifdef PAD_BANK_FILTER_EN
    // filter length shortened mid-count on pad 4
    drv_en[4] = 1'b1; drv_val[4] = 1'b1; flen = 4'd7;
    repeat (2) step();
    drv_val[4] = 1'b0;
    repeat (6) step();
    check("lchg_hold", in_v[4], 1);
    flen = 4'd1; step();
    check("lchg_upd", in_v[4], 0); check("lchg_fall", fall[4], 1);
`endif
    clr = '1; step(); clr = '0;

    // randomized traffic: pads 0-3 driven by the bench, pads 4-7 driven by the DUT
    drv_en = 8'h0F;
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(3) == 0) drv_val[k] = ~drv_val[k];
        if ($urandom_range(15) == 0) mode[2*k +: 2] = ($urandom_range(1) == 1) ? 2'd3 : 2'd0;
      end
      for (int k = 4; k < NP; k++) begin
        if ($urandom_range(7) == 0) mode[2*k +: 2] = 2'($urandom_range(3));
        if ($urandom_range(3) == 0) out[k] = ~out[k];
      end
      if ($urandom_range(31) == 0) flen = FW'($urandom_range(4));
      clr = ($urandom_range(7) == 0) ? NP'($urandom) : '0;
      if (c == 300) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_in", in_v, 0);
        check("arst_rise", rise, 0);
        check("arst_pend", pend, 0);
        check("arst_irq", irq, 0);
        check("arst_pad", pad, pad_model());
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
